pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 160, payload width in bits (min 1).
REQ-002 SHALL have parameter NOP_VALUE, default '0 (WIDTH bits), payload substituted on bubble insertion.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_nop  input  1  replace accepted payload with NOP_VALUE.
REQ-009 SHALL have port in_data  input  WIDTH  producer payload.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  oldest held payload, driven from a register.
REQ-013 SHALL have port level  output  2  number of held entries (0..2).

Function
REQ-014 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, both sampled at the rising edge.
REQ-015 SHALL store NOP_VALUE instead of in_data on push when in_nop=1; entry stays valid.
REQ-016 SHALL present a pushed entry on out_valid/out_data exactly 1 cycle after push; no combinational in_data->out_data path.
REQ-017 SHALL keep strict FIFO order; no entry lost or duplicated except by flush or reset.
REQ-018 SHALL implement states EMPTY, ONE, FULL: EMPTY+push->ONE; ONE+push&!pop->FULL; ONE+pop&!push->EMPTY; ONE+push&pop->ONE (new entry to main); FULL+pop->ONE (skid entry to main); all else hold.
REQ-019 SHALL drive in_ready from a register: 1 in EMPTY/ONE, 0 in FULL; no combinational out_ready->in_ready path.
REQ-020 SHALL drive out_valid=1 in ONE/FULL, level = 0/1/2 for EMPTY/ONE/FULL.
REQ-021 SHALL sustain 1 transfer/cycle while in_valid and out_ready are held high.
REQ-022 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL on flush=1 go to EMPTY next cycle; simultaneous push dropped; simultaneous pop completes (consumer keeps that entry).
REQ-024 SHALL give flush priority over push/pop; reset priority over flush.

Reset
REQ-025 SHALL while reset=1 immediately force EMPTY, out_valid=0, out_data=0, level=0, in_ready=1.
REQ-026 SHALL on reset mid-operation discard all held entries; first push after deassertion appears 1 cycle later.

Configuration
REQ-027 SHALL honour macro PIPE_SKID_STAGE_SKID_EN.
REQ-028 SHALL with PIPE_SKID_STAGE_SKID_EN defined implement the 2-entry skid behaviour of REQ-018..REQ-020.
REQ-029 SHALL without it implement a single register: states EMPTY/ONE only, in_ready = !out_valid | out_ready (combinational), level max 1; all other requirements unchanged.

Structure
REQ-030 SHALL place skid state enum (EMPTY, ONE, FULL) and constant RV_NOP = 32'h00000013 in shared package pipe_pkg.
REQ-031 SHALL be a single module; no sub-module is natural.

Verification (WIDTH=32, NOP_VALUE=32'h00000013, SKID_EN defined unless noted)
REQ-032 SHALL cover streaming: push 0x1,0x2,0x3 back-to-back, out_ready=1 -> out_data 0x1,0x2,0x3 on cycles 1,2,3, level=1 throughout.
REQ-033 SHALL cover backpressure: out_ready=0, push 0xA,0xB -> level=2, in_ready=0, 0xC held off; out_ready=1 -> 0xA,0xB,0xC in order.
REQ-034 SHALL cover bubble: push 0xDEAD with in_nop=1 -> out_data=0x00000013, out_valid=1 next cycle.
REQ-035 SHALL cover flush: FULL with 0xA,0xB, flush=1 with push 0xC and out_ready=1 -> 0xA consumed, next cycle level=0, out_valid=0, 0xC never appears.
REQ-036 SHALL cover reset mid-operation: level=2, assert reset between edges -> out_valid=0, out_data=0, in_ready=1 immediately.
REQ-037 SHALL cover macro undefined: out_ready=0 with one entry -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline skid stage and its users.
//   skid_state_t : occupancy state of a skid stage (EMPTY, ONE, FULL).
//   RV_NOP       : RISC-V canonical NOP (addi x0,x0,0), the usual bubble payload.
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/pipe_skid_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Registered valid/ready pipeline stage with optional 2-entry skid buffer.
//
// Build option (macro PIPE_SKID_STAGE_SKID_EN):
//   defined   : 2-entry skid stage; in_ready comes straight from a register,
//               so there is no out_ready -> in_ready combinational path.
//   undefined : single register; in_ready = !out_valid | out_ready (comb).
//
// Parameters:
//   WIDTH     : payload width in bits (>= 1).
//   NOP_VALUE : payload stored instead of in_data when in_nop is set on push.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset (empties the stage)
//   flush     in   synchronous kill of all held entries
//   in_valid  in   producer offers in_data
//   in_ready  out  stage accepts this cycle
//   in_nop    in   store NOP_VALUE instead of in_data
//   in_data   in   producer payload [WIDTH]
//   out_valid out  out_data holds a valid entry
//   out_ready in   consumer takes out_data this cycle
//   out_data  out  oldest held payload, registered [WIDTH]
//   level     out  number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int               WIDTH     = 160,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_nop,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);
  import pipe_pkg::*;

  skid_state_t      state_r;
  logic [WIDTH-1:0] main_r;      // oldest entry, drives out_data
  logic             out_valid_r;
  logic [1:0]       level_r;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] payload_s;

`ifdef PIPE_SKID_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_r;      // second entry, only used in FULL
  logic             in_ready_r;

  // Ready is a flop: high unless both entries are occupied.
  assign in_ready = in_ready_r;
`else
  // Single register: can accept when empty or when the held entry leaves now.
  assign in_ready = ~out_valid_r | out_ready;
`endif

  // Handshake qualifiers and bubble substitution.
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid_r & out_ready;
  assign payload_s = in_nop ? NOP_VALUE : in_data;

  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign level     = level_r;

  // Occupancy FSM and data registers; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= EMPTY;
      main_r      <= '0;
      out_valid_r <= 1'b0;
      level_r     <= 2'd0;
`ifdef PIPE_SKID_STAGE_SKID_EN
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
`endif
    end else if (flush) begin
      // A pop in this cycle already handed main_r to the consumer; a push is
      // dropped simply by not capturing it.
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      level_r     <= 2'd0;
`ifdef PIPE_SKID_STAGE_SKID_EN
      in_ready_r  <= 1'b1;
`endif
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            main_r      <= payload_s;
            state_r     <= ONE;
            out_valid_r <= 1'b1;
            level_r     <= 2'd1;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            // Streaming: the new entry replaces the one leaving.
            main_r <= payload_s;
          end else if (push_s) begin
`ifdef PIPE_SKID_STAGE_SKID_EN
            // Consumer stalled: park the new entry behind the oldest one.
            skid_r     <= payload_s;
            state_r    <= FULL;
            level_r    <= 2'd2;
            in_ready_r <= 1'b0;
`else
            // Unreachable: in_ready equals out_ready while holding an entry.
            state_r    <= ONE;
`endif
          end else if (pop_s) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            level_r     <= 2'd0;
          end
        end
`ifdef PIPE_SKID_STAGE_SKID_EN
        FULL: begin
          // No push possible here (in_ready_r is low).
          if (pop_s) begin
            main_r     <= skid_r;
            state_r    <= ONE;
            level_r    <= 2'd1;
            in_ready_r <= 1'b1;
          end
        end
`endif
        default: begin
          // Illegal encoding: recover to a clean empty stage.
          state_r     <= EMPTY;
          out_valid_r <= 1'b0;
          level_r     <= 2'd0;
`ifdef PIPE_SKID_STAGE_SKID_EN
          in_ready_r  <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
// Self-checking bench for pipe_skid_stage (WIDTH=32, NOP_VALUE=RV_NOP).
// Reference model: a plain queue holding the stage contents, with a capacity
// of 2 (skid build) or 1 (single-register build).
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_nop;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  level;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_q[$];   // stage contents, oldest first
  logic [31:0] popped[$];    // entries taken by the consumer

  pipe_skid_stage #(
    .WIDTH     (32),
    .NOP_VALUE (RV_NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_nop    (in_nop),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected acceptance given current contents and this cycle's out_ready.
  function automatic logic exp_ready(input logic ordy);
`ifdef PIPE_SKID_STAGE_SKID_EN
    return model_q.size() < 2;
`else
    return (model_q.size() == 0) || ordy;
`endif
  endfunction

  // One clock: drive at negedge, check just after, update model at posedge.
  task automatic step(input logic v, input logic nop, input logic [31:0] d,
                      input logic ordy, input logic fl);
    logic er;
    logic push;
    logic pop;
    @(negedge clk);
    in_valid = v; in_nop = nop; in_data = d; out_ready = ordy; flush = fl;
    #1;
    er = exp_ready(ordy);
    check_value("in_ready",  32'(in_ready),  32'(er));
    check_value("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check_value("level",     32'(level),     32'(model_q.size()));
    if (model_q.size() != 0) check_value("out_data", out_data, model_q[0]);
    push = v & er;
    pop  = (model_q.size() != 0) & ordy;
    @(posedge clk);
    if (pop) popped.push_back(model_q.pop_front());
    if (fl) model_q.delete();
    else if (push) model_q.push_back(nop ? RV_NOP : d);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_nop = 1'b0; in_data = 32'h0; out_ready = 1'b0; flush = 1'b0;
  endtask

  // Assert reset between edges and check outputs respond immediately.
  task automatic mid_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    check_value("rst_valid", 32'(out_valid), 32'h0);
    check_value("rst_data",  out_data,       32'h0);
    check_value("rst_ready", 32'(in_ready),  32'h1);
    check_value("rst_level", 32'(level),     32'h0);
    model_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #2;
    check_value("por_valid", 32'(out_valid), 32'h0);
    check_value("por_data",  out_data,       32'h0);
    check_value("por_ready", 32'(in_ready),  32'h1);
    check_value("por_level", 32'(level),     32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Streaming: 1,2,3 back to back with consumer always ready.
    step(1'b1, 1'b0, 32'h1, 1'b1, 1'b0);
    #2 check_value("str_d1", out_data, 32'h1);
    step(1'b1, 1'b0, 32'h2, 1'b1, 1'b0);
    #2 check_value("str_d2", out_data, 32'h2);
    check_value("str_lvl", 32'(level), 32'h1);
    step(1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
    #2 check_value("str_d3", out_data, 32'h3);
    check_value("str_lvl", 32'(level), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Bubble insertion.
    step(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0);
    #2 check_value("nop_data",  out_data,        32'h00000013);
    check_value("nop_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

`ifdef PIPE_SKID_STAGE_SKID_EN
    // Backpressure: A,B fill the stage, C held off, then drained in order.
    popped.delete();
    step(1'b1, 1'b0, 32'hA, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hB, 1'b0, 1'b0);
    #2 check_value("bp_level", 32'(level),    32'h2);
    check_value("bp_ready", 32'(in_ready), 32'h0);
    step(1'b1, 1'b0, 32'hC, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hC, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'hC, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check_value("bp_count", 32'(popped.size()), 32'h3);
    if (popped.size() == 3) begin
      check_value("bp_ord0", popped[0], 32'hA);
      check_value("bp_ord1", popped[1], 32'hB);
      check_value("bp_ord2", popped[2], 32'hC);
    end

    // Flush from FULL with concurrent push and pop.
    popped.delete();
    step(1'b1, 1'b0, 32'hA, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hB, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hC, 1'b1, 1'b1);
    #2 check_value("fl_level", 32'(level),     32'h0);
    check_value("fl_valid", 32'(out_valid), 32'h0);
    check_value("fl_pop",   32'(popped.size()), 32'h1);
    if (popped.size() == 1) check_value("fl_popval", popped[0], 32'hA);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Reset while FULL, then first push after release.
    step(1'b1, 1'b0, 32'hA, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hB, 1'b0, 1'b0);
    mid_reset();
    step(1'b1, 1'b0, 32'h5, 1'b1, 1'b0);
    #2 check_value("rst_first", out_data, 32'h5);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
`else
    // Single register: in_ready follows out_ready while holding an entry.
    step(1'b1, 1'b0, 32'h7, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 check_value("sr_rdy_lo", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    #1 check_value("sr_rdy_hi", 32'(in_ready), 32'h1);
    check_value("sr_level", 32'(level), 32'h1);
    @(posedge clk);
    popped.push_back(model_q.pop_front());
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    mid_reset();
    step(1'b1, 1'b0, 32'h5, 1'b1, 1'b0);
    #2 check_value("rst_first", out_data, 32'h5);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
`endif

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 70, $urandom_range(99) < 10, $urandom,
           $urandom_range(99) < 60, $urandom_range(99) < 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
